updown_mod_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 55 +++++
 rtl/updown_mod_counter.sv | 96 +++++++++
 tb/tb_updown_mod_counter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the up/down modulus counter
package counter_pkg;

   // Gray code of a binary value is value ^ (value >> GRAY_SHIFT)
   localparam int GRAY_SHIFT = 1;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   // Clamp a value into the legal count range 0..modulus-1
   function automatic int unsigned clamp_mod(input int unsigned value,
                                             input int unsigned modulus);
      return (value >= modulus) ? (modulus - 1) : value;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled cycles down to one counter tick every PRESCALE
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   if (PRESCALE <= 1) begin : g_direct
      // No divider needed: every enabled cycle is a tick
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clr};
      assign tick = en;
   end else begin : g_divider
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] psc_q;
      logic [PW-1:0] psc_d;
      logic          tick_raw;

      // Phase counter: advances on enabled cycles, restarts on its last phase or on clr
      always_comb begin
         psc_d    = psc_q;
         tick_raw = 1'b0;
         if (clr) begin
            psc_d = '0;
         end else if (en) begin
            if (psc_q == PSC_LAST) begin
               psc_d    = '0;
               tick_raw = 1'b1;
            end else begin
               psc_d = psc_q + PW'(1);
            end
         end
      end

      // Phase register with synchronous reset
      always_ff @(posedge clk) begin
         if (reset) begin
            psc_q <= '0;
         end else begin
            psc_q <= psc_d;
         end
      end

      assign tick = tick_raw;
   end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulus counter with load, prescale and terminal count
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 8,
   parameter bit SATURATE = 1'b0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             forward,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] n_gray,
   output logic             at_max,
   output logic             at_min,
   output logic             tc
);

   if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
   end

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("updown_mod_counter: PRESCALE=%0d must be >= 1", PRESCALE);
   end

   localparam logic [WIDTH-1:0] N_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] n_d;
   logic             tc_q;
   logic             tc_d;
   logic             tick;
   logic [WIDTH-1:0] load_clamped;
   dir_t             dir;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .tick  (tick)
   );

   assign dir          = forward ? DIR_UP : DIR_DOWN;
   assign load_clamped = WIDTH'(clamp_mod(32'(load_val), MODULUS));

   // Next count: load wins over tick; boundary ticks wrap or hold and flag tc
   always_comb begin
      n_d  = n_q;
      tc_d = 1'b0;
      if (load) begin
         n_d = load_clamped;
      end else if (tick) begin
         if (dir == DIR_UP) begin
            if (n_q == N_MAX) begin
               tc_d = 1'b1;
               n_d  = SATURATE ? n_q : '0;
            end else begin
               n_d = n_q + WIDTH'(1);
            end
         end else begin
            if (n_q == '0) begin
               tc_d = 1'b1;
               n_d  = SATURATE ? n_q : N_MAX;
            end else begin
               n_d = n_q - WIDTH'(1);
            end
         end
      end
   end

   // Count and terminal-count registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         n_q  <= n_d;
         tc_q <= tc_d;
      end
   end

   assign n      = n_q;
   assign n_gray = n_q ^ (n_q >> GRAY_SHIFT);
   assign at_max = (n_q == N_MAX);
   assign at_min = (n_q == '0);
   assign tc     = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter across four parameter sets
module tb_updown_mod_counter;

   typedef struct {
      int dut;
      bit rst;
      bit en;
      bit fwd;
      bit ld;
      int lv;
      int exp_n;
      bit exp_tc;
   } vec_t;

   typedef struct {
      int dut;
      int exp_n;
      bit exp_tc;
   } exp_t;

   // duts: 0 defaults, 1 MODULUS=6 saturating, 2 WIDTH=4 MODULUS=10, 3 PRESCALE=3
   int mods [4] = '{8, 6, 10, 8};

   logic       clk = 1'b0;
   logic       rst [4];
   logic       en  [4];
   logic       fwd [4];
   logic       ld  [4];
   logic [3:0] lv  [4];

   logic [2:0] n0, g0, n1, g1, n3, g3;
   logic [3:0] n2, g2;
   logic       mx0, mn0, tc0, mx1, mn1, tc1, mx2, mn2, tc2, mx3, mn3, tc3;

   exp_t sb_q[$];
   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   updown_mod_counter u_d0 (
      .clk(clk), .reset(rst[0]), .en(en[0]), .forward(fwd[0]), .load(ld[0]),
      .load_val(lv[0][2:0]), .n(n0), .n_gray(g0), .at_max(mx0), .at_min(mn0), .tc(tc0)
   );

   updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1), .PRESCALE(1)) u_d1 (
      .clk(clk), .reset(rst[1]), .en(en[1]), .forward(fwd[1]), .load(ld[1]),
      .load_val(lv[1][2:0]), .n(n1), .n_gray(g1), .at_max(mx1), .at_min(mn1), .tc(tc1)
   );

   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_d2 (
      .clk(clk), .reset(rst[2]), .en(en[2]), .forward(fwd[2]), .load(ld[2]),
      .load_val(lv[2]), .n(n2), .n_gray(g2), .at_max(mx2), .at_min(mn2), .tc(tc2)
   );

   updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .PRESCALE(3)) u_d3 (
      .clk(clk), .reset(rst[3]), .en(en[3]), .forward(fwd[3]), .load(ld[3]),
      .load_val(lv[3][2:0]), .n(n3), .n_gray(g3), .at_max(mx3), .at_min(mn3), .tc(tc3)
   );

   function automatic vec_t mk(input int d, input bit r, input bit e, input bit f,
                               input bit l, input int v, input int xn, input bit xt);
      vec_t x;
      x.dut = d; x.rst = r; x.en = e; x.fwd = f; x.ld = l; x.lv = v;
      x.exp_n = xn; x.exp_tc = xt;
      return x;
   endfunction

   task automatic sample(input int d, output int an, output int ag,
                         output bit amx, output bit amn, output bit atc);
      case (d)
         0: begin an = int'(n0); ag = int'(g0); amx = mx0; amn = mn0; atc = tc0; end
         1: begin an = int'(n1); ag = int'(g1); amx = mx1; amn = mn1; atc = tc1; end
         2: begin an = int'(n2); ag = int'(g2); amx = mx2; amn = mn2; atc = tc2; end
         default: begin an = int'(n3); ag = int'(g3); amx = mx3; amn = mn3; atc = tc3; end
      endcase
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      int   an, ag, eg;
      bit   amx, amn, atc, emx, emn;
      @(negedge clk);
      rst[v.dut] = v.rst;
      en[v.dut]  = v.en;
      fwd[v.dut] = v.fwd;
      ld[v.dut]  = v.ld;
      lv[v.dut]  = 4'(v.lv);
      e.dut = v.dut; e.exp_n = v.exp_n; e.exp_tc = v.exp_tc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_vec++;
      sample(e.dut, an, ag, amx, amn, atc);
      eg  = e.exp_n ^ (e.exp_n >> 1);
      emx = (e.exp_n == mods[e.dut] - 1);
      emn = (e.exp_n == 0);
      if (an != e.exp_n) begin
         n_err++;
         $display("FAIL n vec%0d dut%0d: got %0d want %0d", n_vec, e.dut, an, e.exp_n);
      end
      if (atc != e.exp_tc) begin
         n_err++;
         $display("FAIL tc vec%0d dut%0d: got %0b want %0b", n_vec, e.dut, atc, e.exp_tc);
      end
      if (ag != eg) begin
         n_err++;
         $display("FAIL n_gray vec%0d dut%0d: got %0d want %0d", n_vec, e.dut, ag, eg);
      end
      if (amx != emx) begin
         n_err++;
         $display("FAIL at_max vec%0d dut%0d: got %0b want %0b", n_vec, e.dut, amx, emx);
      end
      if (amn != emn) begin
         n_err++;
         $display("FAIL at_min vec%0d dut%0d: got %0b want %0b", n_vec, e.dut, amn, emn);
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         rst[d] = 1'b1; en[d] = 1'b0; fwd[d] = 1'b1; ld[d] = 1'b0; lv[d] = 4'd0;
      end

      // defaults, count up through the wrap
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 0, i % 8, i == 8));

      // defaults, count down from reset wraps to 7
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 7, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 6, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0));

      // saturating MODULUS=6 up then down
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 7; i++) tbl.push_back(mk(1, 0, 1, 1, 0, 0, (i < 5) ? i : 5, i > 5));
      for (int i = 4; i >= 0; i--) tbl.push_back(mk(1, 0, 1, 0, 0, 0, i, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));

      // WIDTH=4 MODULUS=10 load clamp and load-beats-tick
      tbl.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, 1, 1, 12, 9, 0));
      tbl.push_back(mk(2, 0, 1, 1, 1, 3, 3, 0));
      tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4, 0));
      tbl.push_back(mk(2, 0, 1, 1, 0, 0, 5, 0));
      tbl.push_back(mk(2, 0, 0, 1, 1, 9, 9, 0));
      tbl.push_back(mk(2, 0, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(2, 0, 0, 1, 1, 15, 9, 0));
      tbl.push_back(mk(2, 0, 0, 1, 1, 10, 9, 0));
      tbl.push_back(mk(2, 0, 1, 0, 0, 0, 8, 0));

      // defaults: reset beats load, reset held with en, load beats tick at max
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 5, 5, 0));
      tbl.push_back(mk(0, 1, 1, 1, 1, 2, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 7, 7, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 3, 3, 0));

      foreach (tbl[i]) apply(tbl[i]);

      // PRESCALE=3: step every third enabled cycle, freeze with en low
      apply(mk(3, 1, 0, 1, 0, 0, 0, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 1, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 1, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 1, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 2, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 2, 0));
      for (int i = 0; i < 4; i++) apply(mk(3, 0, 0, 1, 0, 0, 2, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 2, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 3, 0));

      // direction change keeps prescale phase
      apply(mk(3, 0, 1, 1, 0, 0, 3, 0));
      apply(mk(3, 0, 1, 0, 0, 0, 3, 0));
      apply(mk(3, 0, 1, 0, 0, 0, 2, 0));

      // load mid-phase restarts the prescaler
      apply(mk(3, 0, 1, 1, 0, 0, 2, 0));
      apply(mk(3, 0, 1, 1, 1, 5, 5, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 5, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 5, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 6, 0));

      // reset mid-phase with load clears count and phase
      apply(mk(3, 0, 1, 1, 0, 0, 6, 0));
      apply(mk(3, 1, 1, 1, 1, 2, 0, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(3, 0, 1, 1, 0, 0, 1, 0));

      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
